// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road traffic phase sequencer:
// phase state codes, one-hot {R,Y,G} light codes and the default counter width.
package traffic_pkg;

    localparam int CNT_W_DEFAULT = 4;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5
    } phase_t;

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times one traffic phase. A load always wins over
// a tick; the count saturates at zero so it can sit there while the sequencer
// waits for demand.
module phase_timer #(
    parameter int CNT_W   = 4,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // Count register: reset value, then load, then tick-driven decrement.
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= CNT_W'(RST_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (tick && !zero) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Moore controller for a main/side intersection. Walks a fixed six-phase ring
// timed by a phase_timer, holds main green until side demand is latched, and
// exposes the remaining phase time for the display.
// Optional pedestrian walk feature: define TRAFFIC_PED_WALK_EN to add the
// ped_req input and walk output.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int T_MAIN_GREEN = 9,
    parameter int T_SIDE_GREEN = 5,
    parameter int T_YELLOW     = 2,
    parameter int T_ALL_RED    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             side_req,
`ifdef TRAFFIC_PED_WALK_EN
    input  logic             ped_req,
    output logic             walk,
`endif
    output logic [2:0]       main_lights,
    output logic [2:0]       side_lights,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] counter,
    output logic             phase_done
);

    phase_t           phase_q;
    phase_t           phase_d;
    logic             pending_q;
    logic             pending_d;
    logic             done_q;
    logic             demand;
    logic             expire;
    logic             transition;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] count;
    logic             zero;

`ifdef TRAFFIC_PED_WALK_EN
    assign demand = side_req | ped_req;
`else
    assign demand = side_req;
`endif

    assign expire = tick & zero;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (T_MAIN_GREEN)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .count    (count),
        .zero     (zero)
    );

    // State register: phase, latched side demand and the phase-change pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= MAIN_GREEN;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            pending_q <= pending_d;
            done_q    <= transition;
        end
    end

    // Next-state logic: advance on expiry (main green also needs demand),
    // recover from unused codes, and pick the reload for the phase entered.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        phase_d   = phase_q;
        pending_d = pending_q | demand;
        load_val  = CNT_W'(T_MAIN_GREEN);

        case (phase_q)
            MAIN_GREEN:  if (expire && (pending_q || demand)) phase_d = MAIN_YELLOW;
            MAIN_YELLOW: if (expire) phase_d = ALL_RED_A;
            ALL_RED_A:   if (expire) phase_d = SIDE_GREEN;
            SIDE_GREEN:  if (expire) phase_d = SIDE_YELLOW;
            SIDE_YELLOW: if (expire) phase_d = ALL_RED_B;
            ALL_RED_B:   if (expire) phase_d = MAIN_GREEN;
            default:     phase_d = MAIN_GREEN;
        endcase

        transition = (phase_d != phase_q);
        load       = transition;

        case (phase_d)
            MAIN_YELLOW, SIDE_YELLOW: load_val = CNT_W'(T_YELLOW);
            ALL_RED_A, ALL_RED_B:     load_val = CNT_W'(T_ALL_RED);
            SIDE_GREEN:               load_val = CNT_W'(T_SIDE_GREEN);
            default:                  load_val = CNT_W'(T_MAIN_GREEN);
        endcase

        // Entering side green serves the demand; a request on this same edge
        // is considered served too.
        if (transition && phase_d == SIDE_GREEN) begin
            pending_d = 1'b0;
        end
    end

    // Output decode: light heads follow the phase register only.
    always_comb begin
        main_lights = LIGHT_R;
        side_lights = LIGHT_R;
        case (phase_q)
            MAIN_GREEN:  main_lights = LIGHT_G;
            MAIN_YELLOW: main_lights = LIGHT_Y;
            SIDE_GREEN:  side_lights = LIGHT_G;
            SIDE_YELLOW: side_lights = LIGHT_Y;
            default: begin
                main_lights = LIGHT_R;
                side_lights = LIGHT_R;
            end
        endcase
    end

`ifdef TRAFFIC_PED_WALK_EN
    // Walk stops two ticks before side green ends to give crossing clearance.
    assign walk = (phase_q == SIDE_GREEN) && (count >= CNT_W'(2));
`endif

    assign phase      = phase_q;
    assign counter    = count;
    assign phase_done = done_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench for traffic_phase_sequencer. A behavioural model of the
// phase ring (duration table, pending flag) predicts every output each cycle.
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       side_req = 1'b0;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic [2:0] phase;
    logic [3:0] counter;
    logic       phase_done;
`ifdef TRAFFIC_PED_WALK_EN
    logic       ped_req = 1'b0;
    logic       walk;
    localparam bit PED_ON = 1'b1;
`else
    localparam bit PED_ON = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state
    int m_phase;
    int m_cnt;
    bit m_pend;
    bit m_done;

    localparam int RELOAD [6] = '{9, 2, 1, 5, 2, 1};
    localparam logic [2:0] MAIN_TAB [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    localparam logic [2:0] SIDE_TAB [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

    traffic_phase_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .side_req    (side_req),
`ifdef TRAFFIC_PED_WALK_EN
        .ped_req     (ped_req),
        .walk        (walk),
`endif
        .main_lights (main_lights),
        .side_lights (side_lights),
        .phase       (phase),
        .counter     (counter),
        .phase_done  (phase_done)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] exp_vec();
        return {3'(m_phase), 4'(m_cnt), m_done, MAIN_TAB[m_phase], SIDE_TAB[m_phase]};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {phase, counter, phase_done, main_lights, side_lights};
    endfunction

    // Drive one clock cycle of inputs, advance the model across the edge,
    // then settle 1 time unit past the edge before anyone samples.
    task automatic cycle(input bit t, input bit r, input bit p, input bit rn);
        bit demand;
        bit expire;
        tick     = t;
        side_req = r;
`ifdef TRAFFIC_PED_WALK_EN
        ped_req  = p;
`endif
        rst_n    = rn;
        @(posedge clk);
        demand = r | (p & PED_ON);
        if (!rn) begin
            m_phase = 0;
            m_cnt   = RELOAD[0];
            m_pend  = 1'b0;
            m_done  = 1'b0;
        end else begin
            expire = t && (m_cnt == 0) && (m_phase != 0 || m_pend || demand);
            m_done = expire;
            if (expire) begin
                m_phase = (m_phase + 1) % 6;
                m_cnt   = RELOAD[m_phase];
                m_pend  = (m_phase == 3) ? 1'b0 : (m_pend | demand);
            end else begin
                if (t && m_cnt > 0) m_cnt = m_cnt - 1;
                m_pend = m_pend | demand;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", obs_vec(), exp_vec());
        end
        checks++;
        if (counter !== 4'd9 || main_lights !== 3'b001 || side_lights !== 3'b100) begin
            failures++;
            $display("FAIL reset_const: counter %0d main %b side %b, expected 9 001 100",
                     counter, main_lights, side_lights);
        end
    endtask

    task automatic test_full_cycle();
        int seen [6];
        int done_cnt = 0;
        int want [6] = '{10, 3, 2, 6, 3, 2};
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int p = 0; p < 6; p++) seen[p] = 0;
        if (phase < 3'd6) seen[phase]++;
        for (int i = 1; i <= 26; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL full_cycle[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (i < 26 && phase < 3'd6) seen[phase]++;
            if (phase_done === 1'b1) done_cnt++;
        end
        for (int p = 0; p < 6; p++) begin
            checks++;
            if (seen[p] != want[p]) begin
                failures++;
                $display("FAIL duration_phase%0d: got %0d cycles expected %0d", p, seen[p], want[p]);
            end
        end
        checks++;
        if (done_cnt != 6) begin
            failures++;
            $display("FAIL done_pulses: got %0d expected 6", done_cnt);
        end
        checks++;
        if (phase !== 3'd0 || counter !== 4'd9) begin
            failures++;
            $display("FAIL wrap_to_main: phase %0d counter %0d expected 0 9", phase, counter);
        end
    endtask

    task automatic test_demand_hold();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL demand_hold[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (phase !== 3'd0 || counter !== 4'd0 || main_lights !== 3'b001) begin
            failures++;
            $display("FAIL stuck_green: phase %0d counter %0d main %b expected 0 0 001",
                     phase, counter, main_lights);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (phase !== 3'd1 || counter !== 4'd2 || phase_done !== 1'b1) begin
            failures++;
            $display("FAIL pulse_release: phase %0d counter %0d done %b expected 1 2 1",
                     phase, counter, phase_done);
        end
    endtask

    task automatic test_slow_tick();
        logic [3:0] prev;
        bit t;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        prev = counter;
        for (int i = 0; i < 240; i++) begin
            t = (i % 4 == 3);
            cycle(t, ($urandom_range(0, 3) == 0), 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL slow_tick[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            if (!t) begin
                checks++;
                if (counter !== prev) begin
                    failures++;
                    $display("FAIL hold_no_tick[%0d]: counter %0d expected %0d", i, counter, prev);
                end
            end
            prev = counter;
        end
    endtask

    task automatic test_reset_mid_side();
        bit found = 1'b0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && !found; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b1);
            if (m_phase == 3 && m_cnt == 3) found = 1'b1;
        end
        checks++;
        if (!found || phase !== 3'd3 || counter !== 4'd3) begin
            failures++;
            $display("FAIL reach_side_green: phase %0d counter %0d expected 3 3", phase, counter);
        end
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs_vec() !== exp_vec() || phase !== 3'd0 || counter !== 4'd9) begin
            failures++;
            $display("FAIL mid_reset: got %h expected %h", obs_vec(), exp_vec());
        end
        // With pending cleared by reset and no demand, main green must stall.
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (phase !== 3'd0 || counter !== 4'd0) begin
            failures++;
            $display("FAIL pending_cleared: phase %0d counter %0d expected 0 0", phase, counter);
        end
    endtask

    task automatic test_random();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 199) != 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
            checks++;
            if (main_lights !== 3'b100 && side_lights !== 3'b100) begin
                failures++;
                $display("FAIL conflict[%0d]: main %b side %b, one must be 100", i, main_lights, side_lights);
            end
        end
    endtask

`ifdef TRAFFIC_PED_WALK_EN
    task automatic test_walk();
        int walk_hi = 0;
        bit sg_seen = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (walk !== 1'b0) begin
            failures++;
            $display("FAIL walk_reset: got %b expected 0", walk);
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1);
            checks++;
            if (walk !== (m_phase == 3 && m_cnt >= 2)) begin
                failures++;
                $display("FAIL walk[%0d]: got %b expected %b", i, walk, (m_phase == 3 && m_cnt >= 2));
            end
            if (phase === 3'd3) sg_seen = 1'b1;
            if (walk === 1'b1) walk_hi++;
        end
        checks++;
        if (!sg_seen || walk_hi != 4) begin
            failures++;
            $display("FAIL walk_ticks: side green seen %b, walk high %0d expected 4", sg_seen, walk_hi);
        end
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_full_cycle();
        test_demand_hold();
        test_slow_tick();
        test_reset_mid_side();
        test_random();
`ifdef TRAFFIC_PED_WALK_EN
        test_walk();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, checks %0d failures %0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
